// File: rtl/instruction_loader.sv
// instruction_loader: assembles a big-endian byte stream into imem words, verifies an XOR checksum, then releases the CPU
module instruction_loader #(
   parameter int DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic [15:0] load_len,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_run
);
   localparam int IW = $clog2(DEPTH_WORDS + 1);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RECV  = 3'd1;
   localparam logic [2:0] WRITE = 3'd2;
   localparam logic [2:0] CSUM  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [2:0] ERROR = 3'd5;
   logic [2:0]    state;
   logic [IW-1:0] len, idx, idx_nx;
   logic [1:0]    cnt;
   logic [7:0]    csum;
   logic [31:0]   word;
   logic          take, len_bad;
   assign idx_nx     = idx + IW'(1);
   assign take       = in_valid && in_ready;
   assign len_bad    = load_len == 16'd0 || load_len > 16'(DEPTH_WORDS);
   assign in_ready   = state == RECV || state == CSUM;
   assign imem_we    = state == WRITE;
   assign imem_addr  = 32'({idx, 2'b00});
   assign imem_wdata = word;
   assign busy       = state == RECV || state == WRITE || state == CSUM;
   assign done       = state == DONE;
   assign error      = state == ERROR;
   assign cpu_run    = state == DONE;
   // load sequencer: byte shifting, checksum accumulation, word writes and verdict
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         len   <= '0;
         idx   <= '0;
         cnt   <= '0;
         csum  <= '0;
         word  <= '0;
      end else
         case (state)
            IDLE, DONE, ERROR:
               if (load_start) begin
                  state <= len_bad ? ERROR : RECV;
                  len   <= load_len[IW-1:0];
                  idx   <= '0;
                  cnt   <= '0;
                  csum  <= '0;
                  word  <= '0;
               end
            RECV:
               if (take) begin
                  word <= {word[23:0], in_byte};
                  csum <= csum ^ in_byte;
                  cnt  <= cnt + 2'd1;
                  if (cnt == 2'd3) state <= WRITE;
               end
            WRITE: begin
               idx   <= idx_nx;
               state <= idx_nx == len ? CSUM : RECV;
            end
            CSUM:
               if (take) state <= in_byte == csum ? DONE : ERROR;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized loads checked against a word/checksum reference model
module tb_instruction_loader;
   logic        clk, reset, load_start, in_valid;
   logic [15:0] load_len;
   logic [7:0]  in_byte;
   logic        in_ready, imem_we, busy, done, error, cpu_run;
   logic [31:0] imem_addr, imem_wdata;
   int          checks, failures, widx, cyc;
   logic [7:0]  stim[$];
   logic [63:0] expq[$];
   logic [63:0] mon_e;

   instruction_loader #(.DEPTH_WORDS(64)) dut (
      .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .error(error), .cpu_run(cpu_run)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // every write strobe must match the next expected {addr, word}
   always @(negedge clk)
      if (imem_we) begin
         if (expq.size() == 0) check("spurious_we", 1, 0);
         else begin
            mon_e = expq.pop_front();
            check("we_addr", imem_addr, mon_e[63:32]);
            check("we_data", imem_wdata, mon_e[31:0]);
         end
      end

   task automatic new_load();
      stim.delete();
      widx = 0;
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) stim.push_back(w[8*k +: 8]);
      expq.push_back({32'(widx * 4), w});
      widx++;
   endtask

   task automatic add_csum(input logic bad);
      logic [7:0] x = 8'h00;
      foreach (stim[k]) x ^= stim[k];
      stim.push_back(x ^ {7'd0, bad});
   endtask

   task automatic start(input logic [15:0] len);
      @(negedge clk);
      load_start = 1;
      load_len = len;
      @(negedge clk);
      load_start = 0;
   endtask

   task automatic stream(input int nb, input int pct);
      int i = 0;
      logic rdy;
      cyc = 0;
      while (i < nb && cyc < 5000) begin
         rdy = in_ready;
         in_valid = $urandom_range(99) < pct;
         in_byte = in_valid ? stim[i] : 8'($urandom);
         @(posedge clk);
         if (in_valid && rdy) i++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 0;
      check("stream_bytes", i, nb);
   endtask

   task automatic outcome(input logic ok);
      check("done", done, ok);
      check("cpu_run", cpu_run, ok);
      check("error", error, !ok);
      check("busy_end", busy, 0);
      check("writes_left", expq.size(), 0);
   endtask

   task automatic nominal(input logic [7:0] cs);
      new_load();
      add_word(32'h20080005);
      add_word(32'h8C090000);
      stim.push_back(cs);
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1; load_start = 0; load_len = 0; in_valid = 0; in_byte = 0;
      repeat (3) @(negedge clk);
      check("rst_flags", {in_ready, imem_we, busy, done, error, cpu_run}, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_wdata", imem_wdata, 0);
      reset = 0;
      nominal(8'hA8);
      start(2);
      check("start_ready", in_ready, 1);
      check("start_busy", busy, 1);
      stream(stim.size(), 100);
      check("nominal_cycles", cyc, 11);
      outcome(1);
      nominal(8'hA9);
      start(2);
      stream(stim.size(), 60);
      outcome(0);
      start(0);
      check("len0_error", error, 1);
      check("len0_ready", in_ready, 0);
      check("len0_busy", busy, 0);
      start(65);
      check("len65_error", error, 1);
      check("len65_ready", in_ready, 0);
      new_load();
      for (int w = 0; w < 64; w++) add_word($urandom);
      add_csum(0);
      start(64);
      stream(stim.size(), 100);
      check("len64_cycles", cyc, 321);
      outcome(1);
      nominal(8'hA8);
      start(2);
      stream(stim.size(), 40);
      outcome(1);
      for (int r = 0; r < 6; r++) begin
         int n;
         logic bad;
         n = $urandom_range(1, 64);
         bad = $urandom_range(3) == 0;
         new_load();
         for (int w = 0; w < n; w++) add_word($urandom);
         add_csum(bad);
         start(16'(n));
         stream(stim.size(), $urandom_range(30, 100));
         outcome(!bad);
      end
      nominal(8'hA8);
      start(2);
      stream(6, 70);
      reset = 1;
      @(negedge clk);
      reset = 0;
      expq.delete();
      check("midrst_flags", {in_ready, imem_we, busy, done, error, cpu_run}, 0);
      check("midrst_addr", imem_addr, 0);
      in_valid = 1;
      in_byte = 8'h55;
      repeat (5) @(negedge clk);
      check("midrst_ready", in_ready, 0);
      in_valid = 0;
      nominal(8'hA8);
      start(2);
      stream(stim.size(), 80);
      outcome(1);
      new_load();
      add_word(32'h00000000);
      add_csum(0);
      start(1);
      check("reload_cpu_run", cpu_run, 0);
      check("reload_done", done, 0);
      check("reload_ready", in_ready, 1);
      stream(stim.size(), 100);
      outcome(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Upstream companion to the single-cycle MIPS processor. It receives a program as a byte stream over a valid/ready interface and assembles big-endian 32-bit words. It writes each word into the instruction memory's write port at consecutive word addresses from 0, then checks an XOR checksum. The processor is held halted (`cpu_run` low) until a load completes cleanly, so fetch at PC 0 always sees a complete, verified program.

## Interface
- `DEPTH_WORDS`, default 64: instruction memory capacity in words; upper bound on `load_len`.
- `clk` input 1: system clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `load_start` input 1: one-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `load_len` input 16: number of 32-bit words to load, sampled when `load_start` is accepted.
- `in_valid` input 1: `in_byte` is valid.
- `in_byte` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction memory write strobe.
- `imem_addr` output 32: byte address, equal to word index × 4.
- `imem_wdata` output 32: assembled instruction word.
- `busy` output 1: load in progress (RECV, WRITE or CSUM).
- `done` output 1: last load succeeded.
- `error` output 1: last load failed (bad length or checksum mismatch).
- `cpu_run` output 1: processor enable; PC and register-file writes are gated by it.

## Operation
- The FSM has six states: IDLE, RECV, WRITE, CSUM, DONE, ERROR.
- **IDLE / DONE / ERROR, on `load_start`:**
  - If `load_len` is 0 or greater than `DEPTH_WORDS`, go to ERROR.
  - Otherwise latch the length, clear the word index, byte count and checksum, and go to RECV.
  - In both cases clear `done`, `error` and `cpu_run`.
- **RECV:** `in_ready`=1.
  - Each accepted byte (`in_valid && in_ready`) shifts into the word register, first byte into [31:24].
  - Each accepted byte is XORed into the 8-bit checksum and increments the 2-bit byte count.
  - On acceptance of the 4th byte, go to WRITE.
- **WRITE:** `in_ready`=0, `imem_we`=1 for exactly this cycle.
  - `imem_addr` = index×4; `imem_wdata` = assembled word.
  - Then increment the index. If index+1 == length, go to CSUM; else go to RECV.
- **CSUM:** `in_ready`=1.
  - On acceptance, compare the byte against the running checksum. Match → DONE; mismatch → ERROR.
  - The checksum byte is not XORed into the checksum.
- **DONE:** `done`=1, `cpu_run`=1, `in_ready`=0.
- **ERROR:** `error`=1, `cpu_run`=0, `in_ready`=0. Words already written remain in memory.
- **Ignored inputs:**
  - `load_start` during RECV, WRITE or CSUM.
  - `in_valid` while `in_ready`=0; no byte is consumed.
- **Width rules:**
  - `imem_addr` = {index, 2'b00}, zero-extended to 32 bits.
  - The index counter is wide enough for `DEPTH_WORDS`; it never wraps because length ≤ `DEPTH_WORDS`.

## Timing
- **Reset:** state IDLE, all outputs 0, word register, index, byte count and checksum cleared. Reset mid-load aborts with no further `imem_we`.
- **Latency:**
  - `load_start` to `in_ready`=1: 1 cycle.
  - 4th byte accepted to `imem_we`: 1 cycle.
  - Checksum accepted to `done`/`cpu_run`: 1 cycle.
- **Throughput:** 4 bytes per 5 cycles when `in_valid` is held high (one WRITE bubble per word).
- `in_valid` may drop at any time; the loader waits indefinitely with no timeout.
- All outputs are registered or decoded from state only. `in_ready` has no combinational path from `in_valid`.
- **Back-to-back restart:** `load_start` in the same cycle the FSM enters DONE is not seen. A `load_start` while in DONE drops `cpu_run` on the next edge.

## Test plan
- **Nominal two-word load:** `load_len`=2, bytes 20 08 00 05 8C 09 00 00, checksum A8.
  - `imem_we` pulses with addr 0 / 0x20080005, then addr 4 / 0x8C090000.
  - `done`=1 and `cpu_run`=1 one cycle after A8 is accepted.
- **Bad checksum:** same stream with checksum A9 → `error`=1, `cpu_run`=0, both words still written.
- **Length limits:**
  - `load_len`=0 → ERROR next cycle, no `in_ready` pulse.
  - `load_len`=65 with `DEPTH_WORDS`=64 → ERROR.
  - `load_len`=64 → addresses 0..0xFC written, then DONE.
- **Stalled stream:** random `in_valid` gaps and `in_valid` asserted during WRITE.
  - No byte is lost or duplicated; words and checksum are identical to the nominal case.
- **Reset mid-load:** `reset` after 6 bytes.
  - Next cycle: IDLE, all outputs 0, no further `imem_we`.
  - A fresh nominal load then succeeds.
- **Reload:** `load_start` while in DONE → `cpu_run` drops next cycle. A new 1-word load of 0x00000000 with checksum 00 returns to DONE.
